// File: rtl/pwr_ctrl_pkg.sv
// Shared definitions for the clock-gate power-enable controller.
package pwr_ctrl_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_GATED  = 2'd2,
      ST_WAKE   = 2'd3
   } pwr_state_e;

   // Bits needed to hold values 0..max_val (never less than 1)
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'(1) << i) <= 64'(max_val)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pwr_en_ctrl_if.sv
// Domain / clock-gate signals of the power-enable controller.
interface pwr_en_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             activity;
   logic             wake_req;
   logic             quiesce_ack;
   logic             dbg_force_on;
   logic             quiesce_req;
   logic             pwr_en;
   logic             gating_override;
   logic             domain_ready;
   logic [CNT_W-1:0] gated_cycles;

   // Controller side
   modport master (
      input  activity, wake_req, quiesce_ack, dbg_force_on,
      output quiesce_req, pwr_en, gating_override, domain_ready, gated_cycles
   );

   // Domain / environment side
   modport slave (
      output activity, wake_req, quiesce_ack, dbg_force_on,
      input  quiesce_req, pwr_en, gating_override, domain_ready, gated_cycles
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
   parameter int unsigned W   = 5,
   parameter int unsigned MAX = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;

   // Clear wins over increment; hold once MAX is reached
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != W'(MAX))) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pwr_en_ctrl.sv
// Idle-driven clock-gate controller: idle detect, quiesce handshake, gate, timed wake.
module pwr_en_ctrl
   import pwr_ctrl_pkg::*;
#(
   parameter int unsigned IDLE_CYCLES = 16,
   parameter int unsigned WAKE_CYCLES = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic          clk,
   input  logic          reset,
   pwr_en_ctrl_if.master bus
);

   localparam int unsigned IDLE_W = cnt_width(IDLE_CYCLES);
   localparam int unsigned WAKE_W = cnt_width(WAKE_CYCLES);

   pwr_state_e       state_q;
   logic [IDLE_W-1:0] idle_cnt;
   logic [WAKE_W-1:0] wake_cnt_q;
   logic [CNT_W-1:0]  gated_cycles_q;
   logic              pwr_en_q;
   logic              gating_override_q;
   logic              domain_ready_q;
   logic              quiesce_req_q;

   logic wake_any;
   logic drain_abort;
   logic wake_done;
   logic go_drain;
   logic idle_clr;
   logic idle_inc;

   // Decode of transition conditions from the current state and inputs
   assign wake_any    = bus.activity | bus.wake_req | bus.dbg_force_on;
   assign drain_abort = (state_q == ST_DRAIN) && wake_any;
   assign wake_done   = (state_q == ST_WAKE) && (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1));
   assign go_drain    = (state_q == ST_ACTIVE) && (idle_cnt == IDLE_W'(IDLE_CYCLES)) &&
                        !bus.activity && !bus.wake_req && !bus.dbg_force_on;
   assign idle_inc    = (state_q == ST_ACTIVE) && !bus.activity;
   assign idle_clr    = ((state_q == ST_ACTIVE) && bus.activity) || drain_abort || wake_done;

   sat_counter #(
      .W   (IDLE_W),
      .MAX (IDLE_CYCLES)
   ) u_idle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (idle_clr),
      .inc_i (idle_inc),
      .cnt_o (idle_cnt)
   );

   // FSM with registered outputs; reset forces clocks on
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= ST_ACTIVE;
         pwr_en_q          <= 1'b1;
         gating_override_q <= 1'b1;
         domain_ready_q    <= 1'b1;
         quiesce_req_q     <= 1'b0;
         gated_cycles_q    <= '0;
         wake_cnt_q        <= '0;
      end else begin
         gating_override_q <= bus.dbg_force_on;
         case (state_q)
            ST_ACTIVE: begin
               if (go_drain) begin
                  state_q       <= ST_DRAIN;
                  quiesce_req_q <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_abort) begin
                  state_q       <= ST_ACTIVE;
                  quiesce_req_q <= 1'b0;
               end else if (bus.quiesce_ack) begin
                  state_q        <= ST_GATED;
                  quiesce_req_q  <= 1'b0;
                  pwr_en_q       <= 1'b0;
                  domain_ready_q <= 1'b0;
               end
            end
            ST_GATED: begin
               gated_cycles_q <= gated_cycles_q + CNT_W'(1);
               if (wake_any) begin
                  state_q    <= ST_WAKE;
                  pwr_en_q   <= 1'b1;
                  wake_cnt_q <= '0;
               end
            end
            ST_WAKE: begin
               if (wake_done) begin
                  state_q        <= ST_ACTIVE;
                  domain_ready_q <= 1'b1;
               end else begin
                  wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
               end
            end
            default: begin
               state_q        <= ST_ACTIVE;
               pwr_en_q       <= 1'b1;
               domain_ready_q <= 1'b1;
               quiesce_req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.quiesce_req     = quiesce_req_q;
   assign bus.pwr_en          = pwr_en_q;
   assign bus.gating_override = gating_override_q;
   assign bus.domain_ready    = domain_ready_q;
   assign bus.gated_cycles    = gated_cycles_q;

endmodule

// File: tb/tb_pwr_en_ctrl.sv
// Directed bench for pwr_en_ctrl: vector table on a 32-bit-counter instance,
// hand sequences for async reset and a 4-bit-counter instance.
module tb_pwr_en_ctrl;

   logic clk;
   logic reset;

   pwr_en_ctrl_if #(.CNT_W(32)) b1 ();
   pwr_en_ctrl_if #(.CNT_W(4))  b2 ();

   pwr_en_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(4), .CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b1)
   );

   pwr_en_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(4), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        act;
      logic        wake;
      logic        ack;
      logic        dbg;
      int          n;
      logic        qreq;
      logic        pwr;
      logic        ovr;
      logic        rdy;
      logic [31:0] gc;
   } vec_t;

   vec_t tbl[$];
   int   checks;
   int   errors;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance n rising edges, then park on the following falling edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void add(input logic act, input logic wake, input logic ack,
                               input logic dbg, input int n, input logic qreq,
                               input logic pwr, input logic ovr, input logic rdy,
                               input logic [31:0] gc);
      vec_t v;
      v.act = act; v.wake = wake; v.ack = ack; v.dbg = dbg; v.n = n;
      v.qreq = qreq; v.pwr = pwr; v.ovr = ovr; v.rdy = rdy; v.gc = gc;
      tbl.push_back(v);
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      b1.activity = 1'b0; b1.wake_req = 1'b0; b1.quiesce_ack = 1'b0; b1.dbg_force_on = 1'b0;
      b2.activity = 1'b0; b2.wake_req = 1'b0; b2.quiesce_ack = 1'b0; b2.dbg_force_on = 1'b0;

      //   act wake ack dbg  n    qreq pwr ovr rdy gc
      add(0, 0, 0, 0,  16,  0, 1, 0, 1, 0);    // idle counting up
      add(0, 0, 0, 0,   1,  1, 1, 0, 1, 0);    // quiesce_req in cycle 17
      add(0, 0, 0, 0,   5,  1, 1, 0, 1, 0);    // wait for ack in DRAIN
      add(0, 0, 1, 0,   1,  0, 0, 0, 0, 0);    // ack -> GATED
      add(0, 0, 0, 0,   9,  0, 0, 0, 0, 9);
      add(0, 1, 0, 0,   1,  0, 1, 0, 0, 10);   // wake in 10th gated cycle
      add(0, 0, 0, 0,   3,  0, 1, 0, 0, 10);   // settling
      add(0, 0, 0, 0,   1,  0, 1, 0, 1, 10);   // ready 4 cycles after pwr_en
      add(0, 0, 0, 0,  16,  0, 1, 0, 1, 10);   // idle restarted from 0
      add(0, 0, 0, 0,   1,  1, 1, 0, 1, 10);
      add(1, 0, 1, 0,   1,  0, 1, 0, 1, 10);   // abort beats ack
      add(0, 0, 0, 0,  16,  0, 1, 0, 1, 10);   // idle cleared by abort
      add(0, 0, 0, 0,   1,  1, 1, 0, 1, 10);
      add(0, 0, 1, 0,   1,  0, 0, 0, 0, 10);   // GATED again
      add(0, 0, 0, 1,   1,  0, 1, 1, 0, 11);   // force on -> WAKE, override
      add(0, 0, 0, 1,   3,  0, 1, 1, 0, 11);
      add(0, 0, 0, 1,   1,  0, 1, 1, 1, 11);   // back to ACTIVE
      add(0, 0, 0, 1, 100,  0, 1, 1, 1, 11);   // no drain while forced
      add(0, 0, 0, 0,   1,  1, 1, 0, 1, 11);   // idle saturated, drains at once
      add(0, 1, 0, 0,   1,  0, 1, 0, 1, 11);   // wake_req aborts drain
      add(0, 0, 1, 0,  10,  0, 1, 0, 1, 11);   // ack ignored in ACTIVE
      add(0, 0, 1, 0,   6,  0, 1, 0, 1, 11);
      add(0, 0, 1, 0,   1,  1, 1, 0, 1, 11);
      add(0, 0, 1, 0,   1,  0, 0, 0, 0, 11);   // held ack -> GATED
      add(1, 0, 0, 0,   1,  0, 1, 0, 0, 12);   // activity wakes
      add(1, 0, 0, 0,   4,  0, 1, 0, 1, 12);   // inputs ignored during WAKE
      add(0, 0, 0, 0,  17,  1, 1, 0, 1, 12);
      add(0, 0, 1, 0,   1,  0, 0, 0, 0, 12);
      add(0, 0, 0, 0,   3,  0, 0, 0, 0, 15);

      // reset values
      step(2);
      chk("rst qreq", 32'(b1.quiesce_req), 32'd0);
      chk("rst pwr_en", 32'(b1.pwr_en), 32'd1);
      chk("rst override", 32'(b1.gating_override), 32'd1);
      chk("rst ready", 32'(b1.domain_ready), 32'd1);
      chk("rst gated", b1.gated_cycles, 32'd0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         b1.activity     = tbl[i].act;
         b1.wake_req     = tbl[i].wake;
         b1.quiesce_ack  = tbl[i].ack;
         b1.dbg_force_on = tbl[i].dbg;
         step(tbl[i].n);
         chk($sformatf("row%0d qreq", i), 32'(b1.quiesce_req), 32'(tbl[i].qreq));
         chk($sformatf("row%0d pwr_en", i), 32'(b1.pwr_en), 32'(tbl[i].pwr));
         chk($sformatf("row%0d override", i), 32'(b1.gating_override), 32'(tbl[i].ovr));
         chk($sformatf("row%0d ready", i), 32'(b1.domain_ready), 32'(tbl[i].rdy));
         chk($sformatf("row%0d gated", i), b1.gated_cycles, tbl[i].gc);
      end

      // Async reset while GATED: outputs recover before any clock edge
      b1.activity = 1'b0; b1.wake_req = 1'b0; b1.quiesce_ack = 1'b0; b1.dbg_force_on = 1'b0;
      chk("pre-reset pwr_en", 32'(b1.pwr_en), 32'd0);
      reset = 1'b1;
      #1;
      chk("async pwr_en", 32'(b1.pwr_en), 32'd1);
      chk("async override", 32'(b1.gating_override), 32'd1);
      chk("async ready", 32'(b1.domain_ready), 32'd1);
      chk("async qreq", 32'(b1.quiesce_req), 32'd0);
      chk("async gated", b1.gated_cycles, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // 4-bit counter instance: long drain without ack, then wrap
      step(17);
      chk("w4 drain qreq", 32'(b2.quiesce_req), 32'd1);
      step(40);
      chk("w4 held qreq", 32'(b2.quiesce_req), 32'd1);
      chk("w4 held pwr_en", 32'(b2.pwr_en), 32'd1);
      b2.quiesce_ack = 1'b1;
      step(1);
      chk("w4 gated pwr_en", 32'(b2.pwr_en), 32'd0);
      chk("w4 gated cnt0", 32'(b2.gated_cycles), 32'd0);
      b2.quiesce_ack = 1'b0;
      step(15);
      chk("w4 cnt15", 32'(b2.gated_cycles), 32'd15);
      step(1);
      chk("w4 cnt wrap0", 32'(b2.gated_cycles), 32'd0);
      b2.wake_req = 1'b1;
      step(1);
      chk("w4 cnt wrap1", 32'(b2.gated_cycles), 32'd1);
      chk("w4 wake pwr_en", 32'(b2.pwr_en), 32'd1);
      chk("w4 wake ready", 32'(b2.domain_ready), 32'd0);
      b2.wake_req = 1'b0;
      step(4);
      chk("w4 ready", 32'(b2.domain_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
